// File: rtl/arbitro_bus_rtc.sv
// Arbitrates the RTC bus engine between the CPU port and the refresh scanner.
// Define RTC_INIT_SEQ_EN to add the two-write power-up sequence before REPOSO.
module arbitro_bus_rtc #(
  parameter int PERIODO_REFRESCO = 100000000,
  parameter int TIMEOUT          = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_esc,
  input  logic       cpu_lec,
  input  logic [7:0] cpu_dir,
  input  logic [7:0] cpu_dato,
  output logic       cpu_listo,
  output logic [7:0] cpu_datolec,
  input  logic       scan_hab,
  output logic       bus_esc,
  output logic       bus_lec,
  output logic [7:0] bus_dir,
  output logic [7:0] bus_dato,
  input  logic [7:0] bus_datolec,
  input  logic       bus_listo,
  output logic       mem_we,
  output logic [3:0] mem_dir,
  output logic [7:0] mem_dato,
  output logic       error_bus,
  output logic       listo_init
);

  localparam logic [2:0] REPOSO  = 3'd0;
  localparam logic [2:0] CPU_TX  = 3'd1;
  localparam logic [2:0] SCAN_TX = 3'd2;
  localparam logic [2:0] FIN     = 3'd3;
`ifdef RTC_INIT_SEQ_EN
  localparam logic [2:0] INIT_0  = 3'd4;
  localparam logic [2:0] INIT_1  = 3'd5;
  localparam logic [2:0] EST_INI = INIT_0;
`else
  localparam logic [2:0] EST_INI = REPOSO;
`endif

  localparam int TW = $clog2(PERIODO_REFRESCO);
  localparam int OW = $clog2(TIMEOUT + 1);

  logic [2:0]    estado;
  logic [TW-1:0] tick;
  logic [OW-1:0] tmo;
  logic          pend;
  logic [3:0]    idx;
  logic [3:0]    idx_ini;
  logic [7:0]    tabla;
  logic          tick_fin;
  logic          tmo_fin;
`ifdef RTC_INIT_SEQ_EN
  logic          init_hecho;
`endif

  assign tick_fin = (tick == TW'(PERIODO_REFRESCO - 1));
  assign tmo_fin  = (tmo == OW'(TIMEOUT - 1));
  assign idx_ini  = (idx == 4'd0) ? 4'd1 : idx;

  // Time registers sit at 0x21..0x26, date registers at 0x41..0x43
  always_comb begin
    tabla = 8'h00;
    unique case (1'b1)
      (idx_ini <= 4'd6): tabla = {4'h2, idx_ini};
      (idx_ini >= 4'd7 && idx_ini <= 4'd9):
        tabla = {4'h4, idx_ini - 4'd6};
      default: tabla = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= EST_INI;
      tick        <= '0;
      tmo         <= '0;
      pend        <= 1'b0;
      idx         <= 4'd0;
      cpu_listo   <= 1'b0;
      cpu_datolec <= 8'h00;
      bus_esc     <= 1'b0;
      bus_lec     <= 1'b0;
      bus_dir     <= 8'h00;
      bus_dato    <= 8'h00;
      mem_we      <= 1'b0;
      mem_dir     <= 4'd0;
      mem_dato    <= 8'h00;
      error_bus   <= 1'b0;
      listo_init  <= 1'b0;
`ifdef RTC_INIT_SEQ_EN
      init_hecho  <= 1'b0;
`endif
    end else begin
      cpu_listo <= 1'b0;
      mem_we    <= 1'b0;
      error_bus <= 1'b0;
`ifndef RTC_INIT_SEQ_EN
      listo_init <= 1'b1;
`endif
      if (tick_fin) tick <= '0;
      else tick <= tick + 1'b1;
      // later clears in the FSM take precedence (tick coalesced)
      if (tick_fin && scan_hab) pend <= 1'b1;

      unique case (estado)
        REPOSO: begin
          tmo <= '0;
          if (cpu_lec || cpu_esc) begin
            estado   <= CPU_TX;
            bus_lec  <= cpu_lec;
            bus_esc  <= !cpu_lec;
            bus_dir  <= cpu_dir;
            bus_dato <= cpu_dato;
          end else if (pend && scan_hab) begin
            estado   <= SCAN_TX;
            idx      <= idx_ini;
            bus_lec  <= 1'b1;
            bus_dir  <= tabla;
            bus_dato <= 8'h00;
          end
          if (pend && !scan_hab) begin
            pend <= 1'b0;
            idx  <= 4'd1;
          end
        end
        CPU_TX: begin
          tmo <= tmo + 1'b1;
          if (bus_listo || tmo_fin) begin
            bus_lec     <= 1'b0;
            bus_esc     <= 1'b0;
            cpu_listo   <= 1'b1;
            cpu_datolec <= bus_listo ? bus_datolec : 8'hFF;
            error_bus   <= !bus_listo;
            estado      <= FIN;
          end
        end
        SCAN_TX: begin
          tmo <= tmo + 1'b1;
          if (bus_listo || tmo_fin) begin
            bus_lec   <= 1'b0;
            error_bus <= !bus_listo;
            estado    <= FIN;
            if (bus_listo) begin
              mem_we   <= 1'b1;
              mem_dir  <= idx;
              mem_dato <= bus_datolec;
            end
            if (idx == 4'd9) begin
              idx  <= 4'd1;
              pend <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FIN: begin
`ifdef RTC_INIT_SEQ_EN
          if (listo_init) begin
            estado <= REPOSO;
          end else if (init_hecho) begin
            estado     <= REPOSO;
            listo_init <= 1'b1;
          end else begin
            estado <= INIT_1;
          end
`else
          estado <= REPOSO;
`endif
        end
`ifdef RTC_INIT_SEQ_EN
        INIT_0, INIT_1: begin
          if (!bus_esc) begin
            bus_esc  <= 1'b1;
            bus_dir  <= 8'h02;
            bus_dato <= (estado == INIT_0) ? 8'h10 : 8'h00;
            tmo      <= '0;
          end else begin
            tmo <= tmo + 1'b1;
            if (bus_listo || tmo_fin) begin
              bus_esc    <= 1'b0;
              error_bus  <= !bus_listo;
              init_hecho <= (estado == INIT_1);
              estado     <= FIN;
            end
          end
        end
`endif
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule
